instruction_fetch_unit: RTL and testbench

- Front-end sequencer feeding the instruction register from byte-wide memory.
- Selects PC on the address register file D output and issues two byte reads, low byte then high byte.
- Assembles a 16-bit instruction.
- Drives the address register file RegSel/FunSel so that PC increments once per byte fetched.

---
 rtl/instruction_fetch_unit.sv | 74 +++++++
 tb/tb_instruction_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: two-byte instruction fetch sequencer driving PC increments; optional FETCH_TIMEOUT_EN adds a sticky per-byte wait timeout.
module instruction_fetch_unit #(
  parameter bit HI_FIRST = 1'b0,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Address,
  input  logic [7:0]  MemData,
  input  logic        MemReady,
  output logic [1:0]  OutDSel,
  output logic [2:0]  ArfRegSel,
  output logic [2:0]  ArfFunSel,
  output logic [15:0] MemAddress,
  output logic        MemRead,
  output logic [15:0] IR,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);
  typedef enum logic [1:0] {IDLE, FETCH_1, FETCH_2, DONE} state_t;
  state_t state, next;
  logic fetch, inc, tmo;
  assign fetch = state == FETCH_1 || state == FETCH_2;
  assign inc = fetch && MemReady && !Reset;
`ifdef FETCH_TIMEOUT_EN
  logic [7:0] cnt;
  logic err;
  assign tmo = fetch && !MemReady && cnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (fetch && !MemReady && !tmo) ? cnt + 8'd1 : 8'd0;
      if (tmo) err <= 1'b1;
    end
  end
  assign Error = err;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
  assign tmo = 1'b0;
  assign Error = 1'b0;
`endif
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = Start ? FETCH_1 : IDLE;
      FETCH_1: next = MemReady ? FETCH_2 : tmo ? IDLE : FETCH_1;
      FETCH_2: next = MemReady ? DONE : tmo ? IDLE : FETCH_2;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge Clock) begin
    state <= Reset ? IDLE : next;
  end
  // first phase lands in the low lane unless HI_FIRST swaps the order
  always_ff @(posedge Clock) begin
    if (Reset) IR <= '0;
    else if (inc) begin
      if ((state == FETCH_1) ^ HI_FIRST) IR[7:0] <= MemData;
      else IR[15:8] <= MemData;
    end
  end
  assign OutDSel = 2'b00;
  assign ArfRegSel = inc ? 3'b011 : 3'b111;
  assign ArfFunSel = inc ? 3'b001 : 3'b000;
  assign MemAddress = Address;
  assign MemRead = fetch && !Reset;
  assign Busy = state != IDLE && !Reset;
  assign Done = state == DONE && !Reset;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed bench with a phase-level reference model, a PC/memory environment and literal checks.
module tb_instruction_fetch_unit;
  localparam bit HI = 1'b0;
  localparam int TO = 15;
  logic Clock = 0, Reset = 1, Start = 0, MemReady = 0;
  logic [15:0] Address, MemAddress, IR;
  logic [7:0] MemData;
  logic [1:0] OutDSel;
  logic [2:0] ArfRegSel, ArfFunSel;
  logic MemRead, Busy, Done, Error;
  logic [7:0] mem [0:65535];
  logic [15:0] pc, pc_val;
  logic pc_ld = 0;
  int incs;
  int vec = 0, errs = 0;
  bit armed = 0;

  instruction_fetch_unit #(.HI_FIRST(HI), .TIMEOUT_CYCLES(TO)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Address(Address), .MemData(MemData),
    .MemReady(MemReady), .OutDSel(OutDSel), .ArfRegSel(ArfRegSel), .ArfFunSel(ArfFunSel),
    .MemAddress(MemAddress), .MemRead(MemRead), .IR(IR), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  // address register file stand-in: PC on OutD, increments when enabled with FunSel=001
  assign Address = (OutDSel == 2'b00) ? pc : 16'h0000;
  assign MemData = mem[MemAddress];
  always @(posedge Clock)
    if (pc_ld) begin
      pc <= pc_val;
      incs <= 0;
    end else if (!ArfRegSel[2] && ArfFunSel == 3'b001) begin
      pc <= pc + 16'd1;
      incs <= incs + 1;
    end

  // reference: ph 0=idle, 1=first byte, 2=second byte, 3=done
  int ph, w;
  logic [15:0] m_ir;
  logic m_err;
  always @(posedge Clock)
    if (Reset) begin
      ph <= 0; m_ir <= 16'h0; m_err <= 1'b0; w <= 0;
    end else if (ph == 0) begin
      w <= 0;
      if (Start) ph <= 1;
    end else if (ph == 1 || ph == 2) begin
      if (MemReady) begin
        if ((ph == 1) != HI) m_ir[7:0] <= MemData;
        else m_ir[15:8] <= MemData;
        ph <= ph + 1;
        w <= 0;
      end
`ifdef FETCH_TIMEOUT_EN
      else if (w + 1 == TO) begin
        m_err <= 1'b1;
        ph <= 0;
      end else w <= w + 1;
`endif
    end else ph <= 0;

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    vec++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge Clock)
    if (armed) begin
      logic ie;
      ie = !Reset && (ph == 1 || ph == 2) && MemReady;
      chk("busy", 16'(Busy), 16'(!Reset && ph != 0));
      chk("memread", 16'(MemRead), 16'(!Reset && (ph == 1 || ph == 2)));
      chk("done", 16'(Done), 16'(!Reset && ph == 3));
      chk("regsel", 16'(ArfRegSel), ie ? 16'h3 : 16'h7);
      chk("funsel", 16'(ArfFunSel), ie ? 16'h1 : 16'h0);
      chk("outdsel", 16'(OutDSel), 16'h0);
      chk("memaddr", MemAddress, pc);
      chk("ir", IR, m_ir);
      chk("error", 16'(Error), 16'(m_err));
    end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic ld(input logic [15:0] v);
    pc_val = v;
    pc_ld = 1;
    tick;
    pc_ld = 0;
  endtask

  task automatic fetch_wait(output int n);
    Start = 1;
    tick;
    Start = 0;
    n = 0;
    while (!Done && n < 40) begin
      tick;
      n++;
    end
    chk("done_wait", 16'(Done), 16'h1);
  endtask

  int n;
  initial begin
    mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
    mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
    mem[16'h0020] = 8'h78; mem[16'h0021] = 8'h56;
    ld(16'h0000);
    armed = 1;
    tick;
    Reset = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rst_ir", IR, 16'h0000);
      chk("rst_regsel", 16'(ArfRegSel), 16'h7);
      chk("rst_memread", 16'(MemRead), 16'h0);
      chk("rst_busy", 16'(Busy), 16'h0);
    end
    ld(16'h0010);
    MemReady = 1;
    fetch_wait(n);
    chk("latency", 16'(n), 16'd2);
    chk("ir_basic", IR, 16'h1234);
    chk("pc_basic", pc, 16'h0012);
    chk("incs_basic", 16'(incs), 16'd2);
    tick;
    ld(16'h0010);
    MemReady = 0;
    Start = 1;
    tick;
    for (int i = 0; i < 4; i++) begin
      Start = (i < 2);
      tick;
      chk("stall_addr", MemAddress, 16'h0010);
      chk("stall_pc", pc, 16'h0010);
    end
    Start = 0;
    MemReady = 1;
    n = 0;
    while (!Done && n < 40) begin
      tick;
      n++;
    end
    chk("stall_done", 16'(Done), 16'h1);
    chk("ir_stall", IR, 16'h1234);
    chk("pc_stall", pc, 16'h0012);
    chk("incs_stall", 16'(incs), 16'd2);
    tick; tick;
    chk("start_not_queued", 16'(Busy), 16'h0);
    ld(16'hFFFF);
    fetch_wait(n);
    chk("ir_wrap", IR, 16'hABCD);
    chk("pc_wrap", pc, 16'h0001);
    tick;
    ld(16'h0010);
    Start = 1;
    tick;
    Start = 0;
    tick;
    Reset = 1;
    #1;
    chk("rst_hold_regsel", 16'(ArfRegSel), 16'h7);
    tick;
    Reset = 0;
    MemReady = 0;
    chk("rstmid_ir", IR, 16'h0000);
    chk("rstmid_busy", 16'(Busy), 16'h0);
    chk("rstmid_pc", pc, 16'h0011);
    chk("rstmid_incs", 16'(incs), 16'd1);
    tick;
`ifdef FETCH_TIMEOUT_EN
    ld(16'h0020);
    Start = 1;
    tick;
    Start = 0;
    repeat (14) tick;
    chk("to_early_err", 16'(Error), 16'h0);
    chk("to_early_busy", 16'(Busy), 16'h1);
    tick;
    chk("to_err", 16'(Error), 16'h1);
    chk("to_busy", 16'(Busy), 16'h0);
    chk("to_pc", pc, 16'h0020);
    chk("to_incs", 16'(incs), 16'd0);
    MemReady = 1;
    fetch_wait(n);
    chk("to_refetch_ir", IR, 16'h5678);
    chk("to_sticky", 16'(Error), 16'h1);
`else
    chk("error_tied", 16'(Error), 16'h0);
`endif
    tick;
    armed = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
